// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - shared kinds, opcodes and funct7 constants for the instruction encoder
package instr_enc_pkg;

   typedef enum logic [3:0] {
      K_R      = 4'd0,
      K_I      = 4'd1,
      K_LOAD   = 4'd2,
      K_STORE  = 4'd3,
      K_BRANCH = 4'd4,
      K_JAL    = 4'd5,
      K_JALR   = 4'd6,
      K_LUI    = 4'd7,
      K_AUIPC  = 4'd8,
      K_LI     = 4'd9
   } enc_kind_t;

   typedef enum logic {S_IDLE = 1'b0, S_EMIT2 = 1'b1} enc_state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   // True when v is representable as a bits-wide two's complement value.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
      logic [31:0] m;
      m = 32'hFFFF_FFFF << (bits - 1);
      return ((v & m) == m) || ((v & m) == 32'd0);
   endfunction

endpackage

// File: rtl/instr_enc_pack.sv
// rtl/instr_enc_pack.sv - combinational RV32IM field packer and legality check
// LI expansion outputs exist only with INSTR_ENC_LI_EXPAND_EN defined.
module instr_enc_pack
   import instr_enc_pkg::*;
(
   input  logic [3:0]  kind_i,
   input  logic [2:0]  funct3_i,
   input  logic        alt_i,
   input  logic        mext_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   output logic [31:0] instr_o,
`ifdef INSTR_ENC_LI_EXPAND_EN
   output logic [31:0] instr2_o,
   output logic        two_o,
`endif
   output logic        illegal_o
);

   logic        fit12;
   logic        is_shift;
   logic [11:0] i_imm;
   logic [6:0]  r_f7;

   assign fit12    = fits_signed(imm_i, 12);
   assign is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);
   assign i_imm    = is_shift ? {(alt_i ? F7_ALT : F7_BASE), imm_i[4:0]} : imm_i[11:0];
   assign r_f7     = mext_i ? F7_MEXT : (alt_i ? F7_ALT : F7_BASE);

`ifdef INSTR_ENC_LI_EXPAND_EN
   logic [11:0] li_lo;
   logic [19:0] li_hi;
   // Rounding the upper part compensates for ADDI sign-extending the low 12 bits.
   assign li_lo = imm_i[11:0];
   assign li_hi = imm_i[31:12] + {19'd0, imm_i[11]};
`endif

   always_comb begin
      instr_o   = 32'd0;
      illegal_o = 1'b0;
`ifdef INSTR_ENC_LI_EXPAND_EN
      instr2_o  = 32'd0;
      two_o     = 1'b0;
`endif
      case (kind_i)
         K_R: instr_o = {r_f7, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
         K_I: begin
            illegal_o = !fit12;
            instr_o   = {i_imm, rs1_i, funct3_i, rd_i, OPC_OP_IMM};
         end
         K_LOAD: begin
            illegal_o = !fit12 || (funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                        (funct3_i == 3'b111);
            instr_o   = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
         end
         K_STORE: begin
            illegal_o = !fit12 || (funct3_i > 3'd2);
            instr_o   = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
         end
         K_BRANCH: begin
            illegal_o = imm_i[0] || !fits_signed(imm_i, 13) ||
                        (funct3_i == 3'b010) || (funct3_i == 3'b011);
            instr_o   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], OPC_BRANCH};
         end
         K_JAL: begin
            illegal_o = imm_i[0] || !fits_signed(imm_i, 21);
            instr_o   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
         end
         K_JALR: begin
            illegal_o = !fit12;
            instr_o   = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
         end
         K_LUI: begin
            illegal_o = (imm_i[31:20] != 12'd0);
            instr_o   = {imm_i[19:0], rd_i, OPC_LUI};
         end
         K_AUIPC: begin
            illegal_o = (imm_i[31:20] != 12'd0);
            instr_o   = {imm_i[19:0], rd_i, OPC_AUIPC};
         end
`ifdef INSTR_ENC_LI_EXPAND_EN
         K_LI: begin
            if (li_hi == 20'd0) begin
               instr_o = {li_lo, 5'd0, 3'b000, rd_i, OPC_OP_IMM};
            end else begin
               instr_o = {li_hi, rd_i, OPC_LUI};
               if (li_lo != 12'd0) begin
                  two_o    = 1'b1;
                  instr2_o = {li_lo, rd_i, 3'b000, rd_i, OPC_OP_IMM};
               end
            end
         end
`endif
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - instruction encoder and word stream writer (top)
// INSTR_ENC_LI_EXPAND_EN enables LI expansion with the EMIT2 state and pending word.
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_kind,
   input  logic [2:0]        in_funct3,
   input  logic              in_alt,
   input  logic              in_mext,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   input  logic              base_load,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              err
);

   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;
   logic [31:0]       pk_instr;
   logic              pk_illegal;
   logic              accept, out_hs;

`ifdef INSTR_ENC_LI_EXPAND_EN
   enc_state_t  state_q, state_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] pk_instr2;
   logic        pk_two;
`endif

   instr_enc_pack u_pack (
      .kind_i    (in_kind),
      .funct3_i  (in_funct3),
      .alt_i     (in_alt),
      .mext_i    (in_mext),
      .rd_i      (in_rd),
      .rs1_i     (in_rs1),
      .rs2_i     (in_rs2),
      .imm_i     (in_imm),
      .instr_o   (pk_instr),
`ifdef INSTR_ENC_LI_EXPAND_EN
      .instr2_o  (pk_instr2),
      .two_o     (pk_two),
`endif
      .illegal_o (pk_illegal)
   );

`ifdef INSTR_ENC_LI_EXPAND_EN
   assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
`else
   assign in_ready = !out_valid_q || out_ready;
`endif
   assign accept = in_valid && in_ready;
   assign out_hs = out_valid_q && out_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      err_d       = err_q;
`ifdef INSTR_ENC_LI_EXPAND_EN
      state_d     = state_q;
      pend_d      = pend_q;
`endif
      if (out_hs) out_valid_d = 1'b0;
`ifdef INSTR_ENC_LI_EXPAND_EN
      if ((state_q == S_EMIT2) && out_hs) begin
         out_instr_d = pend_q;
         out_valid_d = 1'b1;
         state_d     = S_IDLE;
      end
`endif
      if (accept) begin
         if (pk_illegal) begin
            err_d = 1'b1;
         end else begin
            out_instr_d = pk_instr;
            out_valid_d = 1'b1;
`ifdef INSTR_ENC_LI_EXPAND_EN
            if (pk_two) begin
               pend_d  = pk_instr2;
               state_d = S_EMIT2;
            end
`endif
         end
      end
      // A base reload overrides the post-handshake increment in the same cycle.
      addr_d = addr_q;
      if (base_load)   addr_d = base_addr;
      else if (out_hs) addr_d = addr_q + ADDR_W'(4);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_instr_q <= 32'd0;
         addr_q      <= BASE_ADDR;
         err_q       <= 1'b0;
`ifdef INSTR_ENC_LI_EXPAND_EN
         state_q     <= S_IDLE;
         pend_q      <= 32'd0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
`ifdef INSTR_ENC_LI_EXPAND_EN
         state_q     <= state_d;
         pend_q      <= pend_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_addr  = addr_q;
   assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_kind;
   logic [2:0]  in_funct3;
   logic        in_alt;
   logic        in_mext;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [15:0] out_addr;
   logic        base_load;
   logic [15:0] base_addr;
   logic        err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_kind   (in_kind),
      .in_funct3 (in_funct3),
      .in_alt    (in_alt),
      .in_mext   (in_mext),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .base_load (base_load),
      .base_addr (base_addr),
      .err       (err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [3:0] k, input logic [2:0] f3, input logic alt,
                      input logic mext, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
      in_kind   = k;
      in_funct3 = f3;
      in_alt    = alt;
      in_mext   = mext;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_imm    = imm;
      in_valid  = 1'b1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      base_load = 1'b0;
      base_addr = 16'h0000;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
      total++; if (out_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", out_addr); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_back_to_back();
      req(4'd0, 3'b000, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
      step();
      total++; if (out_valid !== 1'b1 || out_instr !== 32'h002081B3 || out_addr !== 16'h0000) begin
         bad++; $display("FAIL add got=%b/%h@%h exp=1/002081b3@0000", out_valid, out_instr, out_addr); end
      req(4'd0, 3'b000, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
      step();
      total++; if (out_valid !== 1'b1 || out_instr !== 32'h402081B3 || out_addr !== 16'h0004) begin
         bad++; $display("FAIL sub got=%b/%h@%h exp=1/402081b3@0004", out_valid, out_instr, out_addr); end
      req(4'd0, 3'b000, 1'b1, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
      step();
      total++; if (out_instr !== 32'h022081B3 || out_addr !== 16'h0008) begin
         bad++; $display("FAIL mul_alt_ignored got=%h@%h exp=022081b3@0008", out_instr, out_addr); end
      in_valid = 1'b0;
      step();
      total++; if (out_valid !== 1'b0 || out_addr !== 16'h000C) begin
         bad++; $display("FAIL drain got=%b@%h exp=0@000c", out_valid, out_addr); end
   endtask

   task automatic test_formats();
      logic [31:0] exp_w [6];
      logic [31:0] got_w;
      do_reset();
      exp_w[0] = 32'h80000093; exp_w[1] = 32'h40315093; exp_w[2] = 32'h0020A423;
      exp_w[3] = 32'h008000EF; exp_w[4] = 32'hABCDE0B7; exp_w[5] = 32'hFE209EE3;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: req(4'd1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
            1: req(4'd1, 3'b101, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3);
            2: req(4'd3, 3'b010, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
            3: req(4'd5, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
            4: req(4'd7, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h000A_BCDE);
            default: req(4'd4, 3'b001, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
         endcase
         step();
         got_w = out_instr;
         total++; if (out_valid !== 1'b1 || got_w !== exp_w[i] || out_addr !== 16'(4 * i)) begin
            bad++; $display("FAIL format%0d got=%h@%h exp=%h@%h", i, got_w, out_addr, exp_w[i], 16'(4 * i)); end
      end
      in_valid = 1'b0;
      step();
      // Out-of-range immediates: nothing emitted, address holds.
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: req(4'd1, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
            1: req(4'd4, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4096);
            default: req(4'd7, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
         endcase
         step();
         in_valid = 1'b0;
         total++; if (out_valid !== 1'b0 || out_addr !== 16'h0018 || err !== 1'b1) begin
            bad++; $display("FAIL range%0d got=%b@%h err=%b exp=0@0018 err=1", i, out_valid, out_addr, err); end
      end
   endtask

   task automatic test_branch();
      do_reset();
      req(4'd4, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
      step();
      total++; if (out_valid !== 1'b1 || out_instr !== 32'h00208463) begin
         bad++; $display("FAIL beq got=%b/%h exp=1/00208463", out_valid, out_instr); end
      req(4'd4, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7);
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0 || err !== 1'b1 || out_addr !== 16'h0004) begin
         bad++; $display("FAIL beq_odd got=%b err=%b @%h exp=0 err=1 @0004", out_valid, err, out_addr); end
   endtask

   task automatic test_stall();
      do_reset();
      out_ready = 1'b0;
      req(4'd0, 3'b000, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
      step();
      req(4'd0, 3'b000, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
      for (int i = 0; i < 3; i++) begin
         total++; if (out_valid !== 1'b1 || out_instr !== 32'h002081B3 || out_addr !== 16'h0000 || in_ready !== 1'b0) begin
            bad++; $display("FAIL stall%0d got=%b/%h@%h rdy=%b exp=1/002081b3@0000 rdy=0",
                            i, out_valid, out_instr, out_addr, in_ready); end
         step();
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      total++; if (out_instr !== 32'h402081B3 || out_addr !== 16'h0004) begin
         bad++; $display("FAIL release_word got=%h@%h exp=402081b3@0004", out_instr, out_addr); end
      step();
   endtask

   task automatic test_illegal_load();
      do_reset();
      req(4'd2, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4);
      step();
      total++; if (err !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL load111 got err=%b vld=%b exp err=1 vld=0", err, out_valid); end
      req(4'd2, 3'b010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4);
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_instr !== 32'h00412083 || err !== 1'b1 || out_addr !== 16'h0000) begin
         bad++; $display("FAIL lw_after got=%b/%h@%h err=%b exp=1/00412083@0000 err=1",
                         out_valid, out_instr, out_addr, err); end
      req(4'd10, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0 || out_addr !== 16'h0004) begin
         bad++; $display("FAIL kind10 got=%b@%h exp=0@0004", out_valid, out_addr); end
   endtask

   task automatic test_base_load();
      do_reset();
      req(4'd0, 3'b000, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
      step();
      in_valid  = 1'b0;
      base_load = 1'b1;
      base_addr = 16'h0100;
      step();
      base_load = 1'b0;
      total++; if (out_addr !== 16'h0100 || out_valid !== 1'b0) begin
         bad++; $display("FAIL base_win got=%h vld=%b exp=0100 vld=0", out_addr, out_valid); end
      req(4'd0, 3'b000, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
      step();
      in_valid  = 1'b0;
      total++; if (out_instr !== 32'h402081B3 || out_addr !== 16'h0100) begin
         bad++; $display("FAIL base_word got=%h@%h exp=402081b3@0100", out_instr, out_addr); end
      base_load = 1'b1;
      base_addr = 16'hFFFC;
      out_ready = 1'b0;
      step();
      base_load = 1'b0;
      total++; if (out_valid !== 1'b1 || out_instr !== 32'h402081B3 || out_addr !== 16'hFFFC) begin
         bad++; $display("FAIL base_hold got=%b/%h@%h exp=1/402081b3@fffc", out_valid, out_instr, out_addr); end
      out_ready = 1'b1;
      step();
      total++; if (out_addr !== 16'h0000) begin bad++; $display("FAIL addr_wrap got=%h exp=0000", out_addr); end
   endtask

`ifdef INSTR_ENC_LI_EXPAND_EN
   task automatic test_li();
      do_reset();
      req(4'd9, 3'b000, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_instr !== 32'h123462B7 || out_addr !== 16'h0000 || in_ready !== 1'b0) begin
         bad++; $display("FAIL li_lui got=%b/%h@%h rdy=%b exp=1/123462b7@0000 rdy=0",
                         out_valid, out_instr, out_addr, in_ready); end
      step();
      total++; if (out_valid !== 1'b1 || out_instr !== 32'hFFF28293 || out_addr !== 16'h0004 || in_ready !== 1'b1) begin
         bad++; $display("FAIL li_addi got=%b/%h@%h rdy=%b exp=1/fff28293@0004 rdy=1",
                         out_valid, out_instr, out_addr, in_ready); end
      req(4'd9, 3'b000, 1'b0, 1'b0, 5'd6, 5'd0, 5'd0, 32'd5);
      step();
      total++; if (out_instr !== 32'h00500313 || out_addr !== 16'h0008) begin
         bad++; $display("FAIL li_small got=%h@%h exp=00500313@0008", out_instr, out_addr); end
      req(4'd9, 3'b000, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5000);
      step();
      in_valid = 1'b0;
      total++; if (out_instr !== 32'h123453B7 || out_addr !== 16'h000C || in_ready !== 1'b1) begin
         bad++; $display("FAIL li_upper got=%h@%h rdy=%b exp=123453b7@000c rdy=1", out_instr, out_addr, in_ready); end
      step();
      req(4'd4, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7);
      step();
      req(4'd9, 3'b000, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
      step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || out_addr !== 16'h0000 || err !== 1'b0) begin
         bad++; $display("FAIL li_reset got=%b@%h err=%b exp=0@0000 err=0", out_valid, out_addr, err); end
      step();
      rst_n = 1'b1;
      step();
      step();
      total++; if (out_valid !== 1'b0 || out_addr !== 16'h0000) begin
         bad++; $display("FAIL li_pending_dropped got=%b@%h exp=0@0000", out_valid, out_addr); end
   endtask
`else
   task automatic test_li();
      do_reset();
      req(4'd9, 3'b000, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0 || err !== 1'b1 || out_addr !== 16'h0000) begin
         bad++; $display("FAIL li_disabled got=%b err=%b @%h exp=0 err=1 @0000", out_valid, err, out_addr); end
      req(4'd0, 3'b000, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
      step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || out_addr !== 16'h0000 || err !== 1'b0) begin
         bad++; $display("FAIL mid_reset got=%b@%h err=%b exp=0@0000 err=0", out_valid, out_addr, err); end
      step();
      rst_n = 1'b1;
      step();
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_kind   = 4'd0;
      in_funct3 = 3'd0;
      in_alt    = 1'b0;
      in_mext   = 1'b0;
      in_rd     = 5'd0;
      in_rs1    = 5'd0;
      in_rs2    = 5'd0;
      in_imm    = 32'd0;
      out_ready = 1'b1;
      base_load = 1'b0;
      base_addr = 16'h0000;
      test_reset();
      test_back_to_back();
      test_formats();
      test_li();
      test_branch();
      test_stall();
      test_illegal_load();
      test_base_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
